// File: rtl/tiny_loader_pkg.sv
// tiny_loader_pkg: shared loader state encodings and word width
package tiny_loader_pkg;
  localparam int LD_DW = 16;
  localparam logic [2:0] LD_IDLE = 3'd0;
  localparam logic [2:0] LD_LEN  = 3'd1;
  localparam logic [2:0] LD_DATA = 3'd2;
  localparam logic [2:0] LD_SUM  = 3'd3;
  localparam logic [2:0] LD_RUN  = 3'd4;
  localparam logic [2:0] LD_DONE = 3'd5;
  localparam logic [2:0] LD_ERR  = 3'd6;
endpackage

// File: rtl/tiny_loader_byte_pack.sv
// tiny_byte_pack: pairs big-endian host bytes into words with a hi/lo phase flag
module tiny_byte_pack
  import tiny_loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             take,
  input  logic [7:0]       byte_in,
  output logic             word_done,
  output logic [LD_DW-1:0] word
);
  logic       phase_q, phase_d;
  logic [7:0] hi_q, hi_d;
  assign word_done = take & phase_q;
  assign word      = {hi_q, byte_in};
  // phase toggles per accepted byte; the first byte of a pair is latched as the high byte
  always_comb begin
    phase_d = clr ? 1'b0 : take ? ~phase_q : phase_q;
    hi_d    = (take & ~phase_q) ? byte_in : hi_q;
  end
  // phase and high-byte registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end
endmodule

// File: rtl/tiny_loader.sv
// tiny_loader: loads a checksummed program image into CPU RAM and releases the CPU
module tiny_loader
  import tiny_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [LD_DW-1:0]  ram_d,
  output logic              cpu_hold,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err
);
  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d, n_q, n_d;
  logic [LD_DW-1:0]  sum_q, sum_d, ram_d_q, ram_d_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              done_q, done_d, err_q, err_d, hold_q, hold_d, load_q, load_d;
  logic              wd, len_ok;
  logic [LD_DW-1:0]  w;
  assign in_ready = state_q inside {LD_LEN, LD_DATA, LD_SUM};
  assign cpu_run  = state_q == LD_RUN;
  assign busy     = in_ready | cpu_run;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign err      = err_q;
  assign ram_load = load_q;
  assign ram_addr = ram_addr_q;
  assign ram_d    = ram_d_q;
  assign len_ok   = (w != '0) && (32'(w) <= DEPTH);
  // the phase flag restarts on every state change so each state begins on a high byte
  tiny_byte_pack u_pack (
    .clk       (clk),
    .reset     (reset),
    .clr       (state_d != state_q),
    .take      (in_valid & in_ready),
    .byte_in   (in_data),
    .word_done (wd),
    .word      (w)
  );
  // loader FSM: length check, data writes with running checksum, checksum verify, CPU release
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    sum_d      = sum_q;
    done_d     = done_q;
    err_d      = err_q;
    hold_d     = hold_q;
    load_d     = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_d_d    = ram_d_q;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: if (start) begin
        state_d = LD_LEN;
        idx_d   = '0;
        sum_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        hold_d  = 1'b1;
      end
      LD_LEN: if (wd) begin
        n_d     = (ADDR_W+1)'(w);
        state_d = len_ok ? LD_DATA : LD_ERR;
        err_d   = ~len_ok;
      end
      LD_DATA: if (wd) begin
        load_d     = 1'b1;
        ram_addr_d = idx_q[ADDR_W-1:0];
        ram_d_d    = w;
        sum_d      = sum_q + w;
        idx_d      = idx_q + 1'b1;
        state_d    = (idx_q == n_q - 1'b1) ? LD_SUM : LD_DATA;
      end
      LD_SUM: if (wd) begin
        state_d = (w == sum_q) ? LD_RUN : LD_ERR;
        hold_d  = w != sum_q;
        err_d   = w != sum_q;
      end
      LD_RUN: begin
        state_d = LD_DONE;
        done_d  = 1'b1;
      end
      default: state_d = LD_IDLE;
    endcase
  end
  // state, counters and registered RAM write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LD_IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      sum_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b0;
      load_q     <= 1'b0;
      ram_addr_q <= '0;
      ram_d_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      sum_q      <= sum_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
      load_q     <= load_d;
      ram_addr_q <= ram_addr_d;
      ram_d_q    <= ram_d_d;
    end
  end
endmodule

// File: tb/tb_tiny_loader.sv
// tb_tiny_loader: randomized frame loads checked against a frame-level reference model
module tb_tiny_loader;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, ram_load, cpu_hold, cpu_run, busy, done, err;
  logic [11:0] ram_addr;
  logic [15:0] ram_d;
  int cmp = 0, bad = 0, runs = 0;
  typedef struct {logic [11:0] a; logic [15:0] d;} wr_t;
  wr_t wq[$];

  tiny_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ram_load(ram_load), .ram_addr(ram_addr), .ram_d(ram_d),
    .cpu_hold(cpu_hold), .cpu_run(cpu_run), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_load) wq.push_back('{ram_addr, ram_d});
    if (cpu_run) runs++;
  end

  function automatic bit model_good(input logic [15:0] fr[$]);
    int n = int'(fr[0]);
    logic [15:0] s = '0;
    if (n < 1 || n > 4096 || fr.size() < n + 2) return 1'b0;
    for (int i = 1; i <= n; i++) s += fr[i];
    return s == fr[n+1];
  endfunction

  function automatic int model_writes(input logic [15:0] fr[$]);
    int n = int'(fr[0]);
    return (n >= 1 && n <= 4096) ? n : 0;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int t = 0;
    while (gappy && $urandom_range(1, 0) == 1) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      cmp++; bad++;
      $display("FAIL ready_timeout in_ready=0 required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done || err) && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!(done || err)) begin
      cmp++; bad++;
      $display("FAIL end_timeout done=%0b err=%0b required one of them", done, err);
    end
    @(negedge clk);
  endtask

  task automatic test_frame(input string nm, input logic [15:0] fr[$], input bit gappy);
    bit g = model_good(fr);
    int nw = model_writes(fr);
    wq.delete();
    runs  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmp++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_hold_busy hold=%0b busy=%0b required 1 1", nm, cpu_hold, busy);
    end
    foreach (fr[i]) begin
      send_byte(fr[i][15:8], gappy);
      send_byte(fr[i][7:0], gappy);
    end
    wait_end();
    cmp++;
    if (wq.size() != nw) begin
      bad++;
      $display("FAIL %s_nwrites got %0d required %0d", nm, wq.size(), nw);
    end
    for (int i = 0; i < wq.size() && i < nw; i++) begin
      cmp++;
      if (wq[i].a !== 12'(i) || wq[i].d !== fr[i+1]) begin
        bad++;
        $display("FAIL %s_write%0d got %h:%h required %h:%h", nm, i, wq[i].a, wq[i].d, 12'(i), fr[i+1]);
      end
    end
    cmp++;
    if ({done, err, cpu_hold, in_ready, busy} !== {g, !g, !g, 1'b0, 1'b0} || runs != int'(g)) begin
      bad++;
      $display("FAIL %s_status done/err/hold/rdy/busy=%b runs=%0d required %b runs=%0d",
               nm, {done, err, cpu_hold, in_ready, busy}, runs, {g, !g, !g, 1'b0, 1'b0}, int'(g));
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    cmp++;
    if ({in_ready, ram_load, ram_addr, ram_d, cpu_hold, cpu_run, busy, done, err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got %h required 0",
               {in_ready, ram_load, ram_addr, ram_d, cpu_hold, cpu_run, busy, done, err});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    test_frame("basic", '{16'h0002, 16'h0123, 16'h4567, 16'h468A}, 1'b0);
    test_frame("badsum", '{16'h0002, 16'h0123, 16'h4567, 16'h468B}, 1'b0);
  endtask

  task automatic test_bad_len();
    test_frame("len0", '{16'h0000}, 1'b0);
    test_frame("len4097", '{16'h1001}, 1'b0);
  endtask

  task automatic test_gappy();
    test_frame("wrap", '{16'h0003, 16'hFFFF, 16'h0001, 16'h8000, 16'h8000}, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      logic [15:0] fr[$];
      logic [15:0] s = '0;
      int n = $urandom_range(8, 1);
      fr.push_back(16'(n));
      for (int i = 0; i < n; i++) begin
        fr.push_back(16'($urandom));
        s += fr[i+1];
      end
      fr.push_back($urandom_range(3, 0) == 0 ? s ^ 16'(1 << $urandom_range(15, 0)) : s);
      test_frame($sformatf("rand%0d", k), fr, k[0]);
    end
  endtask

  task automatic test_start_same_edge();
    logic [15:0] fr[$] = '{16'h0001, 16'h0005, 16'h0005};
    wq.delete();
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    foreach (fr[i]) begin
      send_byte(fr[i][15:8], 1'b0);
      send_byte(fr[i][7:0], 1'b0);
    end
    wait_end();
    cmp++;
    if (done !== 1'b1 || err !== 1'b0 || wq.size() != 1) begin
      bad++;
      $display("FAIL start_edge done=%0b err=%0b writes=%0d required 1 0 1", done, err, wq.size());
    end
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    #2 reset = 1'b0;
    #1;
    cmp++;
    if ({in_ready, ram_load, ram_addr, ram_d, cpu_hold, cpu_run, busy, done, err} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got %h required 0",
               {in_ready, ram_load, ram_addr, ram_d, cpu_hold, cpu_run, busy, done, err});
    end
    @(negedge clk);
    wq.delete();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    cmp++;
    if (wq.size() != 0 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
      bad++;
      $display("FAIL midreset_idle writes=%0d busy=%0b hold=%0b required 0 0 0", wq.size(), busy, cpu_hold);
    end
    test_frame("afterreset", '{16'h0002, 16'hABCD, 16'h1234, 16'hBE01}, 1'b0);
  endtask

  task automatic test_full();
    logic [15:0] fr[$];
    logic [15:0] s = '0;
    fr.push_back(16'd4096);
    for (int i = 0; i < 4096; i++) begin
      fr.push_back(16'(i));
      s += 16'(i);
    end
    fr.push_back(s);
    cmp++;
    if (s !== 16'hF800) begin
      bad++;
      $display("FAIL full_model_sum got %h required F800", s);
    end
    test_frame("full", fr, 1'b0);
    cmp++;
    if (wq.size() == 0 || wq[wq.size()-1].a !== 12'hFFF) begin
      bad++;
      $display("FAIL full_last_addr got %h required FFF", wq.size() ? wq[wq.size()-1].a : 12'h0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_len();
    test_gappy();
    test_random();
    test_start_same_edge();
    test_mid_reset();
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/tiny_loader.md
# tiny_loader

Program loader for the tiny stack CPU: receives a byte stream from a host link, assembles 16-bit instruction words, and writes them into the CPU's program RAM starting at address 0. It holds the CPU in reset while loading, verifies a checksum, and issues a one-cycle run pulse only when the image is good. It is the writer side of the RAM port the CPU fetches from, and sits between the host byte link and the RAM/state-machine inputs.

## Interface
Parameters:
- ADDR_W, 12, RAM address width.
- DEPTH, 4096, RAM depth in words; the maximum accepted image length.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled in IDLE, DONE, ERR only.
- in_data  in  8  host byte.
- in_valid  in  1  host byte valid.
- in_ready  out  1  loader accepts a byte this cycle.
- ram_load  out  1  RAM write strobe, one cycle per word.
- ram_addr  out  ADDR_W  RAM write address.
- ram_d  out  16  RAM write data.
- cpu_hold  out  1  active-high reset to the CPU during a load.
- cpu_run  out  1  one-cycle run pulse to the CPU.
- busy  out  1  high from the LEN state through the RUN state.
- done  out  1  sticky: image loaded and CPU started.
- err  out  1  sticky: bad length or checksum.

## Operation
- Frame, big-endian, high byte first: LEN word N, then N data words, then SUM word = 16-bit sum of the data words, modulo 2^16.
- A byte transfers on a rising edge with in_valid & in_ready. A hi/lo phase flag pairs bytes into words. The flag clears on every state entry.
- FSM states: IDLE, LEN, DATA, SUM, RUN, DONE, ERR.
- IDLE/DONE/ERR + start -> LEN. On that edge: clear done/err, word index, checksum, phase; set cpu_hold=1.
- LEN: in_ready=1. When the word completes:
  - N in 1..DEPTH -> DATA.
  - N=0 or N>DEPTH -> ERR.
- DATA: in_ready=1. Each completed word writes to ram_addr=index. The checksum accumulates the word. The index increments. After word N-1 -> SUM.
- SUM: in_ready=1. When the word completes:
  - equal to the accumulated checksum -> RUN.
  - otherwise -> ERR.
- RUN: one cycle. cpu_hold=0 and cpu_run=1 in the same cycle, then -> DONE, done=1.
- ERR: err=1 and cpu_hold stays 1, so the CPU remains parked on a bad image.
- in_ready=0 in IDLE, RUN, DONE and ERR.
- Host bytes offered while in_ready=0 are not consumed.
- start is ignored in LEN/DATA/SUM/RUN.

## Timing
- Reset (asynchronous): every output is 0, state=IDLE, index/checksum/phase are 0.
- A reset asserted mid-load aborts with no further RAM writes. After reset, cpu_hold=0.
- in_ready is a function of state only and does not depend on in_valid.
- Back-to-back bytes sustain one byte per cycle.
- RAM write is registered: ram_load, ram_addr and ram_d are valid for exactly the one cycle after the edge that accepted the low byte. This gives latency 1 from the low-byte acceptance edge.
- ram_addr/ram_d hold their last values when ram_load=0.
- The last DATA word's write cycle coincides with the first SUM-state cycle; this is legal.
- The SUM comparison is made on the edge accepting the SUM low byte. RUN occurs in the next cycle, and cpu_run is high for exactly one cycle.
- Index width is ADDR_W+1, so N=DEPTH completes without wrap. The checksum wraps modulo 2^16.
- start on the same edge as an in_valid byte from IDLE: the byte is not consumed, because in_ready was 0 that cycle.

## Structure
- Shared package (e.g. tiny_pkg / defs.v):
  - loader state encodings LD_IDLE..LD_ERR (3-bit).
  - LD_DW=16.
- One natural sub-module, tiny_byte_pack: hi/lo phase flag plus a high-byte register. It emits a word-complete strobe and a 16-bit word, and has a clear input.
- The FSM, index counter, checksum and RAM write register live in tiny_loader.

## Test plan
- start; bytes 00 02, 01 23, 45 67, 46 8A -> RAM[0]=0x0123, RAM[1]=0x4567, two ram_load pulses, cpu_run one cycle, done=1, err=0, cpu_hold 1->0.
- Same frame with SUM 46 8B -> err=1, cpu_run never asserted, cpu_hold stays 1, two RAM writes occurred.
- LEN 00 00, and separately LEN 10 01 (4097) -> ERR right after the LEN low byte, in_ready=0, zero RAM writes.
- in_valid toggled randomly (50%) over a 3-word frame FF FF, 00 01, 80 00, SUM 80 00 -> identical RAM contents, done=1. Checksum wraps: 0xFFFF+0x0001+0x8000=0x8000.
- Reset driven low mid-DATA after one word -> outputs 0 asynchronously, state IDLE. A subsequent full load succeeds.
- N=4096 with data word i=i -> last write at ram_addr=0xFFF, SUM=0xF800 accepted, done=1.
